// File: rtl/wheel_evnt_pkg.sv
// rtl/wheel_evnt_pkg.sv - register map, bit positions and period-state enum for wheel_evnt_capture
package wheel_evnt_pkg;

  localparam logic [4:0] OFS_CTRL   = 5'h00;
  localparam logic [4:0] OFS_CNT0   = 5'h04;
  localparam logic [4:0] OFS_CNT1   = 5'h08;
  localparam logic [4:0] OFS_PER0   = 5'h0C;
  localparam logic [4:0] OFS_PER1   = 5'h10;
  localparam logic [4:0] OFS_STATUS = 5'h14;

  localparam int CTRL_EN_LSB      = 0;
  localparam int CTRL_IE_LSB      = 2;
  localparam int CTRL_CLR_BIT     = 4;
  localparam int STATUS_NEW_LSB   = 0;
  localparam int STATUS_STALL_LSB = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } per_state_e;

endpackage

// File: rtl/wheel_evnt_chan.sv
// rtl/wheel_evnt_chan.sv - one wheel: sync, debounce, rising-edge detect, pulse counter, period timer
module wheel_evnt_chan
  import wheel_evnt_pkg::*;
#(
  parameter int DEB_CYCLES = 64,
  parameter int CNT_W      = 16,
  parameter int PER_W      = 24
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic             evnt_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [PER_W-1:0] per_o,
  output logic             stall_o,
  output logic             cap_o
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_MAX  = '1;

  logic [1:0]       sync_q;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             filt_q, filt_d, filt_prev_q, edge_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] timer_q, timer_d, per_q, per_d;
  logic             stall_q, stall_d;
  per_state_e       state_q, state_d;
  logic             timing, edge_act, capture;

  // A sample equal to the filtered level restarts the disagreement run.
  always_comb begin
    deb_d  = '0;
    filt_d = filt_q;
    if (sync_q[1] != filt_q) begin
      if (deb_q == DEB_LAST) begin
        filt_d = sync_q[1];
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync_q      <= '0;
      deb_q       <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      edge_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], evnt_i};
      deb_q       <= deb_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      edge_q      <= filt_q & ~filt_prev_q;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_i || !en_i) begin
      state_d = IDLE;
    end else if (edge_q) begin
      state_d = (state_q == IDLE) ? ARMED : RUN;
    end
  end

  always_comb begin
    timing   = (state_q != IDLE);
    edge_act = edge_q & en_i & ~clr_i;
    capture  = edge_act & timing;
  end

  // Edge has priority over saturation; a saturated timer captures as all-ones.
  always_comb begin
    cnt_d   = cnt_q;
    timer_d = timer_q;
    per_d   = per_q;
    stall_d = stall_q;
    if (clr_i) begin
      cnt_d   = '0;
      timer_d = '0;
      per_d   = '0;
      stall_d = 1'b0;
    end else if (!en_i) begin
      timer_d = '0;
    end else if (edge_act) begin
      cnt_d   = cnt_q + CNT_W'(1);
      timer_d = '0;
      stall_d = 1'b0;
      if (capture) per_d = (timer_q == PER_MAX) ? PER_MAX : timer_q + PER_W'(1);
    end else if (timing && timer_q != PER_MAX) begin
      timer_d = timer_q + PER_W'(1);
      if (timer_d == PER_MAX) begin
        stall_d = 1'b1;
        per_d   = PER_MAX;
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      cnt_q   <= '0;
      timer_q <= '0;
      per_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      per_q   <= per_d;
      stall_q <= stall_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign per_o   = per_q;
  assign stall_o = stall_q;
  assign cap_o   = capture;

endmodule

// File: rtl/wheel_evnt_capture.sv
// rtl/wheel_evnt_capture.sv - two-wheel encoder odometry with register port and capture interrupt
module wheel_evnt_capture
  import wheel_evnt_pkg::*;
#(
  parameter int DEB_CYCLES = 64,
  parameter int CNT_W      = 16,
  parameter int PER_W      = 24
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic [1:0]  Evnt,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq
);

  logic [1:0]            en_q, ie_q, new_q, new_d, stall, cap;
  logic                  clr_q, irq_q, rvalid_q;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0][PER_W-1:0] per;
  logic [4:0]            ofs;
  logic                  wr_ctrl, wr_status;
  logic                  unused_bits;

  assign ofs         = {addr[4:2], 2'b00};
  assign wr_ctrl     = req & we & (ofs == OFS_CTRL);
  assign wr_status   = req & we & (ofs == OFS_STATUS);
  assign unused_bits = ^{wdata[31:5], addr[1:0]};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    wheel_evnt_chan #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W),
      .PER_W     (PER_W)
    ) u_chan (
      .clk_sys_i (clk_sys),
      .rst_sys_ni(rst_sys_n),
      .evnt_i    (Evnt[g]),
      .en_i      (en_q[g]),
      .clr_i     (clr_q),
      .cnt_o     (cnt[g]),
      .per_o     (per[g]),
      .stall_o   (stall[g]),
      .cap_o     (cap[g])
    );
  end

  // A capture in the same cycle as a W1C keeps NEW set.
  always_comb begin
    new_d = (new_q & ~(wr_status ? wdata[STATUS_NEW_LSB +: 2] : 2'b00)) | cap;
    if (clr_q) new_d = 2'b00;
  end

  always_comb begin
    rdata_d = '0;
    if (req && !we) begin
      case (ofs)
        OFS_CTRL:   rdata_d = {28'd0, ie_q, en_q};
        OFS_CNT0:   rdata_d = 32'(cnt[0]);
        OFS_CNT1:   rdata_d = 32'(cnt[1]);
        OFS_PER0:   rdata_d = 32'(per[0]);
        OFS_PER1:   rdata_d = 32'(per[1]);
        OFS_STATUS: rdata_d = {28'd0, stall, new_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      en_q     <= '0;
      ie_q     <= '0;
      clr_q    <= 1'b0;
      new_q    <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q <= wdata[CTRL_EN_LSB +: 2];
        ie_q <= wdata[CTRL_IE_LSB +: 2];
      end
      clr_q    <= wr_ctrl & wdata[CTRL_CLR_BIT];
      new_q    <= new_d;
      irq_q    <= |(new_q & ie_q);
      rdata_q  <= rdata_d;
      rvalid_q <= req;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

endmodule
